// File: rtl/ctrl_pkg.sv
// Shared decode constants and select encodings for the rysyCore RV32I control path.
// Imported by the controller and by the datapath muxes.
package ctrl_pkg;

    localparam logic [4:0] OpLoad   = 5'b00000;
    localparam logic [4:0] OpOpImm  = 5'b00100;
    localparam logic [4:0] OpAuipc  = 5'b00101;
    localparam logic [4:0] OpStore  = 5'b01000;
    localparam logic [4:0] OpOp     = 5'b01100;
    localparam logic [4:0] OpLui    = 5'b01101;
    localparam logic [4:0] OpBranch = 5'b11000;
    localparam logic [4:0] OpJalr   = 5'b11001;
    localparam logic [4:0] OpJal    = 5'b11011;

    localparam logic [2:0] F3AddSub  = 3'b000;
    localparam logic [2:0] F3Shr     = 3'b101;
    localparam logic [6:0] F7Base    = 7'b0000000;
    localparam logic [6:0] F7Alt     = 7'b0100000;
    localparam int unsigned F7AltBit = 5;

    typedef enum logic [3:0] {
        AluAdd  = 4'b0000, AluSub = 4'b1000, AluSll = 4'b0001, AluSlt = 4'b0010,
        AluSltu = 4'b0011, AluXor = 4'b0100, AluSrl = 4'b0101, AluSra = 4'b1101,
        AluOr   = 4'b0110, AluAnd = 4'b0111
    } alu_op_e;

    typedef enum logic [2:0] {
        ImmI = 3'b000, ImmS = 3'b001, ImmB = 3'b010, ImmU = 3'b011, ImmJ = 3'b100
    } imm_type_e;

    typedef enum logic [1:0] {
        PcPlus4 = 2'b00, PcImm = 2'b01, PcAlu = 2'b10, PcHold = 2'b11
    } pc_sel_e;

    typedef enum logic [1:0] {
        RdAlu = 2'b00, RdLoad = 2'b01, RdPc4 = 2'b10, RdImm = 2'b11
    } rd_sel_e;

    typedef enum logic [1:0] {
        InstMem = 2'b00, InstNop = 2'b01, InstHold = 2'b10
    } inst_sel_e;

    typedef enum logic [0:0] {
        StRun      = 1'b0,
        StLoadWait = 1'b1
    } fsm_e;

endpackage

// File: rtl/ctrl.sv
// Main decoder and sequencer: combinational datapath selects from opcode/func fields,
// plus a two-bit state for the load's second cycle and the bubble after a redirect.
module ctrl
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       b,
    output logic [2:0] imm_type,
    output logic [1:0] inst_sel,
    output logic       reg_wr,
    output logic [3:0] alu_op,
    output logic [2:0] cmp_op,
    output logic [1:0] pc_sel,
    output logic       mem_sel,
    output logic [1:0] rd_sel,
    output logic       alu1_sel,
    output logic       alu2_sel,
    output logic [2:0] sel_type,
    output logic       we
);

    fsm_e fsm_q, fsm_d;
    logic flush_q, flush_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= StRun;
            flush_q <= 1'b1;
        end else begin
            fsm_q   <= fsm_d;
            flush_q <= flush_d;
        end
    end

    always_comb begin
        imm_type = ImmI;
        inst_sel = InstMem;
        reg_wr   = 1'b0;
        alu_op   = AluAdd;
        cmp_op   = 3'b000;
        pc_sel   = PcPlus4;
        mem_sel  = 1'b0;
        rd_sel   = RdAlu;
        alu1_sel = 1'b0;
        alu2_sel = 1'b0;
        sel_type = 3'b000;
        we       = 1'b0;
        fsm_d    = StRun;
        flush_d  = 1'b0;

        if (rst) begin
            inst_sel = InstNop;
            pc_sel   = PcHold;
        end else if (fsm_q == StLoadWait) begin
            // Instruction is held, so the address/width decode stays that of the load.
            inst_sel = InstHold;
            imm_type = ImmI;
            alu2_sel = 1'b1;
            mem_sel  = 1'b1;
            rd_sel   = RdLoad;
            reg_wr   = 1'b1;
            sel_type = func3;
        end else if (flush_q) begin
            inst_sel = InstNop;
        end else begin
            case (opcode)
                OpOp: begin
                    reg_wr = 1'b1;
                    alu_op = {func7[F7AltBit], func3};
                end
                OpOpImm: begin
                    imm_type = ImmI;
                    alu2_sel = 1'b1;
                    reg_wr   = 1'b1;
                    // Only shifts use func7; an immediate add never becomes SUB.
                    alu_op   = (func3 == F3Shr) ? {func7[F7AltBit], F3Shr} : {1'b0, func3};
                end
                OpLoad: begin
                    imm_type = ImmI;
                    alu2_sel = 1'b1;
                    mem_sel  = 1'b1;
                    sel_type = func3;
                    pc_sel   = PcHold;
                    fsm_d    = StLoadWait;
                end
                OpStore: begin
                    imm_type = ImmS;
                    alu2_sel = 1'b1;
                    mem_sel  = 1'b1;
                    we       = 1'b1;
                    sel_type = func3;
                end
                OpBranch: begin
                    imm_type = ImmB;
                    cmp_op   = func3;
                    pc_sel   = b ? PcImm : PcPlus4;
                    flush_d  = b;
                end
                OpJal: begin
                    imm_type = ImmJ;
                    pc_sel   = PcImm;
                    rd_sel   = RdPc4;
                    reg_wr   = 1'b1;
                    flush_d  = 1'b1;
                end
                OpJalr: begin
                    imm_type = ImmI;
                    alu2_sel = 1'b1;
                    pc_sel   = PcAlu;
                    rd_sel   = RdPc4;
                    reg_wr   = 1'b1;
                    flush_d  = 1'b1;
                end
                OpLui: begin
                    imm_type = ImmU;
                    rd_sel   = RdImm;
                    reg_wr   = 1'b1;
                end
                OpAuipc: begin
                    imm_type = ImmU;
                    alu1_sel = 1'b1;
                    alu2_sel = 1'b1;
                    reg_wr   = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl.sv
// Self-checking bench for ctrl: directed cases and randomized instruction streams
// compared against a behavioural model of the decoder and its load/bubble sequencing.
module tb_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       b;
    logic [2:0] imm_type;
    logic [1:0] inst_sel;
    logic       reg_wr;
    logic [3:0] alu_op;
    logic [2:0] cmp_op;
    logic [1:0] pc_sel;
    logic       mem_sel;
    logic [1:0] rd_sel;
    logic       alu1_sel;
    logic       alu2_sel;
    logic [2:0] sel_type;
    logic       we;

    int checks = 0;
    int errors = 0;

    // Model state: a load's second cycle is pending, or a bubble is due.
    bit m_load_wait;
    bit m_bubble;

    always #5 clk = ~clk;

    ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .func3    (func3),
        .func7    (func7),
        .b        (b),
        .imm_type (imm_type),
        .inst_sel (inst_sel),
        .reg_wr   (reg_wr),
        .alu_op   (alu_op),
        .cmp_op   (cmp_op),
        .pc_sel   (pc_sel),
        .mem_sel  (mem_sel),
        .rd_sel   (rd_sel),
        .alu1_sel (alu1_sel),
        .alu2_sel (alu2_sel),
        .sel_type (sel_type),
        .we       (we)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] observed();
        return {imm_type, inst_sel, reg_wr, alu_op, cmp_op, pc_sel, mem_sel, rd_sel,
                alu1_sel, alu2_sel, sel_type, we};
    endfunction

    // Expected select vector, built field by field from the instruction rules.
    function automatic logic [23:0] model(input logic [4:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic bb,
                                          input logic r);
        logic [2:0] e_imm = 3'd0;  logic [1:0] e_inst = 2'd0; logic e_wr = 1'b0;
        logic [3:0] e_alu = 4'd0;  logic [2:0] e_cmp = 3'd0;  logic [1:0] e_pc = 2'd0;
        logic e_mem = 1'b0;        logic [1:0] e_rd = 2'd0;   logic e_a1 = 1'b0;
        logic e_a2 = 1'b0;         logic [2:0] e_sel = 3'd0;  logic e_we = 1'b0;
        if (r) begin
            e_inst = 2'b01; e_pc = 2'b11;
        end else if (m_load_wait) begin
            e_inst = 2'b10; e_a2 = 1'b1; e_mem = 1'b1; e_rd = 2'b01; e_wr = 1'b1; e_sel = f3;
        end else if (m_bubble) begin
            e_inst = 2'b01;
        end else if (op == 5'b01100) begin
            e_wr = 1'b1; e_alu = {f7[5], f3};
        end else if (op == 5'b00100) begin
            e_a2 = 1'b1; e_wr = 1'b1;
            e_alu = (f3 == 3'd5) ? {f7[5], f3} : {1'b0, f3};
        end else if (op == 5'b00000) begin
            e_a2 = 1'b1; e_mem = 1'b1; e_sel = f3; e_pc = 2'b11;
        end else if (op == 5'b01000) begin
            e_imm = 3'd1; e_a2 = 1'b1; e_mem = 1'b1; e_we = 1'b1; e_sel = f3;
        end else if (op == 5'b11000) begin
            e_imm = 3'd2; e_cmp = f3; e_pc = bb ? 2'b01 : 2'b00;
        end else if (op == 5'b11011) begin
            e_imm = 3'd4; e_pc = 2'b01; e_rd = 2'b10; e_wr = 1'b1;
        end else if (op == 5'b11001) begin
            e_a2 = 1'b1; e_pc = 2'b10; e_rd = 2'b10; e_wr = 1'b1;
        end else if (op == 5'b01101) begin
            e_imm = 3'd3; e_rd = 2'b11; e_wr = 1'b1;
        end else if (op == 5'b00101) begin
            e_imm = 3'd3; e_a1 = 1'b1; e_a2 = 1'b1; e_wr = 1'b1;
        end
        return {e_imm, e_inst, e_wr, e_alu, e_cmp, e_pc, e_mem, e_rd, e_a1, e_a2, e_sel, e_we};
    endfunction

    // Apply an instruction and compare at the falling edge.
    task automatic drive(input string tag, input logic [4:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic bb);
        opcode = op; func3 = f3; func7 = f7; b = bb;
        @(negedge clk);
        check(tag, {8'd0, observed()}, {8'd0, model(op, f3, f7, bb, rst)});
    endtask

    // Clock the DUT and advance the model by the same rules.
    task automatic advance();
        @(posedge clk);
        if (m_load_wait) begin
            m_load_wait = 1'b0;
        end else if (m_bubble) begin
            m_bubble = 1'b0;
        end else if (opcode == 5'b00000) begin
            m_load_wait = 1'b1;
        end else if (opcode == 5'b11011 || opcode == 5'b11001 ||
                     (opcode == 5'b11000 && b)) begin
            m_bubble = 1'b1;
        end
        #1;
    endtask

    initial begin
        logic [4:0] ops [9] = '{5'b00000, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
                                5'b01101, 5'b11000, 5'b11001, 5'b11011};
        rst = 1'b1; opcode = 5'b01100; func3 = 3'd0; func7 = 7'd0; b = 1'b0;
        m_load_wait = 1'b0; m_bubble = 1'b1;
        #1;
        check("rst_pc_sel", {30'd0, pc_sel}, 32'h3);
        check("rst_inst_sel", {30'd0, inst_sel}, 32'h1);
        check("rst_reg_wr", {31'd0, reg_wr}, 32'h0);
        drive("rst_vector", 5'b01100, 3'd0, 7'd0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        drive("post_rst_bubble", 5'b01100, 3'd0, 7'd0, 1'b0);
        check("post_rst_no_wr", {31'd0, reg_wr}, 32'h0);
        advance();

        drive("op_sub", 5'b01100, 3'b000, 7'b0100000, 1'b0);
        check("op_sub_alu", {28'd0, alu_op}, 32'h8);
        advance();
        drive("op_add", 5'b01100, 3'b000, 7'b0000000, 1'b0);
        check("op_add_alu", {28'd0, alu_op}, 32'h0);
        advance();
        drive("op_slt", 5'b01100, 3'b010, 7'd0, 1'b0); advance();
        drive("op_xor", 5'b01100, 3'b100, 7'd0, 1'b0); advance();
        drive("op_sll", 5'b01100, 3'b001, 7'd0, 1'b0); advance();
        drive("op_sra", 5'b01100, 3'b101, 7'b0100000, 1'b0);
        check("op_sra_alu", {28'd0, alu_op}, 32'hd);
        advance();
        drive("op_srl", 5'b01100, 3'b101, 7'd0, 1'b0); advance();
        drive("opimm_addi", 5'b00100, 3'b000, 7'b0100000, 1'b0);
        check("opimm_no_sub", {28'd0, alu_op}, 32'h0);
        advance();
        drive("opimm_srai", 5'b00100, 3'b101, 7'b0100000, 1'b0); advance();
        drive("store", 5'b01000, 3'b010, 7'd0, 1'b0);
        check("store_we", {31'd0, we}, 32'h1);
        advance();

        drive("jalr", 5'b11001, 3'b000, 7'd0, 1'b0);
        check("jalr_pc_sel", {30'd0, pc_sel}, 32'h2);
        advance();
        drive("jalr_bubble", 5'b01100, 3'b000, 7'd0, 1'b0);
        check("jalr_bubble_inst", {30'd0, inst_sel}, 32'h1);
        advance();

        drive("load_c1", 5'b00000, 3'b010, 7'd0, 1'b0);
        check("load_c1_pc_hold", {30'd0, pc_sel}, 32'h3);
        advance();
        drive("load_c2", 5'b00000, 3'b010, 7'd0, 1'b0);
        check("load_c2_rd_sel", {30'd0, rd_sel}, 32'h1);
        check("load_c2_reg_wr", {31'd0, reg_wr}, 32'h1);
        advance();

        drive("br_not_taken", 5'b11000, 3'b001, 7'd0, 1'b0); advance();
        drive("after_nt", 5'b01101, 3'b000, 7'd0, 1'b0);
        check("after_nt_inst", {30'd0, inst_sel}, 32'h0);
        advance();
        drive("br_taken", 5'b11000, 3'b111, 7'd0, 1'b1);
        check("br_taken_pc", {30'd0, pc_sel}, 32'h1);
        advance();
        drive("br_bubble", 5'b11011, 3'b000, 7'd0, 1'b0);
        check("br_bubble_inst", {30'd0, inst_sel}, 32'h1);
        advance();

        // Reset pulse while the load's second cycle is pending.
        drive("load_abort_c1", 5'b00000, 3'b100, 7'd0, 1'b0);
        advance();
        rst = 1'b1;
        #1;
        check("abort_reg_wr", {31'd0, reg_wr}, 32'h0);
        check("abort_inst_sel", {30'd0, inst_sel}, 32'h1);
        m_load_wait = 1'b0; m_bubble = 1'b1;
        drive("abort_vector", 5'b00000, 3'b100, 7'd0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive("abort_bubble", 5'b00000, 3'b100, 7'd0, 1'b0);
        advance();

        for (int i = 0; i < 400; i++) begin
            logic [4:0] op;
            logic [2:0] f3;
            logic [6:0] f7;
            if (m_load_wait) begin
                op = opcode; f3 = func3; f7 = func7;
            end else begin
                int k = $urandom_range(0, 11);
                op = (k < 9) ? ops[k] : 5'($urandom);
                f3 = 3'($urandom);
                f7 = $urandom_range(0, 1) ? 7'b0100000 : 7'($urandom);
            end
            drive("random", op, f3, f7, 1'($urandom));
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
